// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, canonical NOP, reset PC and the
// {pc, instr} entry carried from fetch to decode.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Instruction fetches are always word aligned; low address bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; DEPTH must be a
// power of two so the pointers wrap naturally.
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; count alone decides which
   // entries are meaningful, so the array can map onto plain RAM/flops.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited word fetches, tags them
// with their PC, buffers responses and flushes/discards on redirect.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instruction,
   output logic [31:0] instruction_pc,
   output logic        instruction_valid,
   input  logic        instruction_ready
);

   localparam int            CW      = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   iq_count;
   logic [XLEN-1:0] tag_head;
   fetch_entry_t    iq_head;
   fetch_entry_t    iq_entry;
   logic            handshake;
   logic            req_fire;
   logic            resp_keep;
   logic [CW:0]     in_use;

   assign handshake = instruction_valid && instruction_ready;
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_keep = imem_resp_valid && !redirect_valid && (drop == '0);
   assign iq_entry  = '{pc: tag_head, instr: imem_resp_data};

   // An entry leaving the queue this cycle frees its credit immediately, which
   // is what lets a 1-cycle memory sustain one instruction per cycle.
   assign in_use = {1'b0, iq_count} + {1'b0, outstanding} - {{CW{1'b0}}, handshake};

   assign imem_req_valid    = !reset && !redirect_valid && (in_use < DEPTH_C);
   assign imem_req_addr     = pc;
   assign instruction_valid = (iq_count != '0);

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      instruction    = INSTR_NOP;
      instruction_pc = RESET_PC;
      if (instruction_valid) begin
         instruction    = iq_head.instr;
         instruction_pc = iq_head.pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc   <= RESET_PC;
         drop <= '0;
      end else if (redirect_valid) begin
         pc   <= align_word(redirect_pc);
         drop <= outstanding - CW'(imem_resp_valid);
      end else begin
         if (req_fire) pc <= pc + 32'd4;
         if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
   end

   // Tag FIFO occupancy is the outstanding-request count; it is never flushed
   // because stale responses still arrive and must retire their tags.
   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (XLEN)
   ) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (req_fire),
      .push_data (pc),
      .pop       (imem_resp_valid),
      .flush     (1'b0),
      .head      (tag_head),
      .count     (outstanding)
   );

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_instr_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (resp_keep),
      .push_data (iq_entry),
      .pop       (handshake),
      .flush     (redirect_valid),
      .head      (iq_head),
      .count     (iq_count)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-configurable memory model
// feeds a scoreboard of expected {pc, word} pairs checked at each handshake.
module tb_instruction_fetch;
   import cpu_pkg::*;

   localparam int QD = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] instruction;
   logic [31:0] instruction_pc;
   logic        instruction_valid;
   logic        instruction_ready;

   instruction_fetch #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_req_valid    (imem_req_valid),
      .imem_req_addr     (imem_req_addr),
      .imem_req_ready    (imem_req_ready),
      .imem_resp_valid   (imem_resp_valid),
      .imem_resp_data    (imem_resp_data),
      .instruction       (instruction),
      .instruction_pc    (instruction_pc),
      .instruction_valid (instruction_valid),
      .instruction_ready (instruction_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t        pend[$];
   fetch_entry_t exp_q[$];

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          lat = 1;
   int          out_model = 0;
   int          exp_drop = 0;
   int          acc_n = 0;
   int          delivered = 0;
   logic        rdr = 1'b0;
   logic [31:0] rdr_pc = '0;
   logic        rdy = 1'b1;
   logic        mrdy = 1'b1;
   logic        arm = 1'b0;
   logic        fired = 1'b0;
   logic        resp_this;
   logic        o_req_valid;
   logic [31:0] o_req_addr;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] first_acc_addr;
   logic [31:0] first_del_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0073_0293;
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle: present memory response and controls after the falling
   // edge, observe settled outputs, update the model, then take the rising edge.
   task automatic cycle();
      fetch_entry_t e;
      logic         acc;
      @(negedge clock);
      resp_this = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend[0].addr);
         void'(pend.pop_front());
         resp_this = 1'b1;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      instruction_ready = rdy;
      imem_req_ready    = mrdy;
      redirect_pc       = rdr_pc;
      redirect_valid    = rdr;
      if (arm && resp_this && instruction_valid && rdy) begin
         redirect_valid = 1'b1;
         arm   = 1'b0;
         fired = 1'b1;
      end
      #1;
      o_req_valid   = imem_req_valid;
      o_req_addr    = imem_req_addr;
      o_instr_valid = instruction_valid;
      o_instr       = instruction;
      if (instruction_valid && instruction_ready) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else begin
            e.pc    = 'x;
            e.instr = 'x;
         end
         check("sb_instr", instruction, e.instr);
         check("sb_pc", instruction_pc, e.pc);
         if (delivered == 0) first_del_pc = instruction_pc;
         delivered++;
      end
      if (redirect_valid) begin
         exp_q.delete();
         exp_drop = out_model - int'(resp_this);
      end
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
         pend.push_back('{addr: imem_req_addr, due: cyc + lat});
         exp_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
         if (acc_n == 0) first_acc_addr = imem_req_addr;
         acc_n++;
      end
      out_model = out_model + int'(acc) - int'(resp_this);
      @(posedge clock);
      cyc++;
   endtask

   // Asynchronous reset a little after a rising edge; outputs must already be
   // at reset values before the next edge.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_instr_valid", 32'(instruction_valid), 32'd0);
      check("rst_instr", instruction, 32'h0000_0013);
      check("rst_instr_pc", instruction_pc, 32'h0);
      pend.delete();
      exp_q.delete();
      out_model       = 0;
      rdr             = 1'b0;
      arm             = 1'b0;
      fired           = 1'b0;
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      acc_n           = 0;
      delivered       = 0;
      @(posedge clock);
      #2 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset             = 1'b1;
      redirect_valid    = 1'b0;
      redirect_pc       = '0;
      imem_req_ready    = 1'b1;
      imem_resp_valid   = 1'b0;
      imem_resp_data    = '0;
      instruction_ready = 1'b1;

      // 1-cycle memory, free-running consumer
      lat = 1; rdy = 1'b1; mrdy = 1'b1;
      do_reset();
      cycle();
      check("t1_req_valid_c0", 32'(o_req_valid), 32'd1);
      check("t1_addr_c0", o_req_addr, 32'h0);
      cycle();
      check("t1_addr_c1", o_req_addr, 32'h4);
      check("t1_valid_c1", 32'(o_instr_valid), 32'd0);
      cycle();
      check("t1_addr_c2", o_req_addr, 32'h8);
      check("t1_valid_c2", 32'(o_instr_valid), 32'd1);
      check("t1_instr_c2", o_instr, 32'h0073_0293);
      check("t1_first_pc", first_del_pc, 32'h0);
      repeat (5) cycle();
      check("t1_throughput", 32'(delivered), 32'd6);

      // Consumer stalled: credit limit, then redirect into an idle memory
      rdy = 1'b0;
      do_reset();
      repeat (6) cycle();
      check("t2_accepts", 32'(acc_n), 32'(QD));
      check("t2_req_blocked", 32'(o_req_valid), 32'd0);
      check("t2_queue_full_valid", 32'(o_instr_valid), 32'd1);
      rdr = 1'b1; rdr_pc = 32'h0000_2001;
      cycle();
      rdr = 1'b0;
      check("t2_no_req_on_redirect", 32'(o_req_valid), 32'd0);
      cycle();
      check("t2_req_after_redirect", 32'(o_req_valid), 32'd1);
      check("t2_target_addr", o_req_addr, 32'h0000_2000);
      check("t2_flushed", 32'(o_instr_valid), 32'd0);
      rdy = 1'b1;
      delivered = 0;
      for (int i = 0; i < 10 && delivered == 0; i++) cycle();
      check("t2_delivered", 32'(delivered > 0), 32'd1);
      check("t2_first_pc", first_del_pc, 32'h0000_2000);

      // Redirect with two requests in flight to a 3-cycle memory
      lat = 3; rdy = 1'b1;
      do_reset();
      cycle();
      cycle();
      #1 check("t3_outstanding", 32'(dut.outstanding), 32'd2);
      rdr = 1'b1; rdr_pc = 32'h0000_0103;
      cycle();
      rdr = 1'b0;
      #1 check("t3_drop", 32'(dut.drop), 32'(exp_drop));
      check("t3_drop_two", 32'(exp_drop), 32'(out_model));
      acc_n = 0; delivered = 0;
      cycle();
      check("t3_valid_after", 32'(o_instr_valid), 32'd0);
      for (int i = 0; i < 20 && delivered == 0; i++) cycle();
      check("t3_delivered", 32'(delivered > 0), 32'd1);
      check("t3_first_req", first_acc_addr, 32'h0000_0100);
      check("t3_first_pc", first_del_pc, 32'h0000_0100);

      // Redirect in the same cycle as a response and a consumer handshake
      lat = 1; rdy = 1'b1;
      do_reset();
      repeat (3) cycle();
      rdr_pc = 32'h0000_0400;
      arm = 1'b1;
      for (int i = 0; i < 10 && !fired; i++) cycle();
      #1 check("t4_fired", 32'(fired), 32'd1);
      check("t4_drop", 32'(dut.drop), 32'(exp_drop));
      check("t4_outstanding", 32'(dut.outstanding), 32'(out_model));
      cycle();
      check("t4_queue_empty", 32'(o_instr_valid), 32'd0);
      check("t4_req_target", o_req_addr, 32'h0000_0400);
      repeat (4) cycle();

      // Memory not ready: address and pc hold; then wrap at the top of memory
      lat = 1; rdy = 1'b1; mrdy = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t5_stall_valid", 32'(o_req_valid), 32'd1);
         check("t5_stall_addr", o_req_addr, 32'h0);
      end
      #1 check("t5_pc_held", dut.pc, 32'h0);
      rdr = 1'b1; rdr_pc = 32'hFFFF_FFFE;
      cycle();
      rdr = 1'b0; mrdy = 1'b1;
      delivered = 0;
      cycle();
      check("t5_top_addr", o_req_addr, 32'hFFFF_FFFC);
      #1 check("t5_pc_wrapped", dut.pc, 32'h0);
      cycle();
      check("t5_wrap_addr", o_req_addr, 32'h0);
      repeat (4) cycle();
      check("t5_delivered", 32'(delivered), 32'd4);
      check("t5_first_pc", first_del_pc, 32'hFFFF_FFFC);

      // Reset in the middle of a stream
      lat = 1; rdy = 1'b1; mrdy = 1'b1;
      do_reset();
      repeat (5) cycle();
      do_reset();
      cycle();
      check("t6_restart_valid", 32'(o_req_valid), 32'd1);
      check("t6_restart_addr", o_req_addr, 32'h0);
      repeat (3) cycle();
      check("t6_delivered", 32'(delivered), 32'd2);
      check("t6_first_pc", first_del_pc, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
